lut_access_ctrl: RTL

LUT_ACCESS_CTRL -- requirements
Module: lut_access_ctrl

---
 rtl/lut_access_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/lut_access_ctrl.sv
// lut_access_ctrl: 8x1 lookup table shared by two read clients with
// round-robin arbitration and a 1-cycle registered read path. The table
// can be reloaded serially; reads are held off while a reload is running.
module lut_access_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [2:0] addr0,
    input  logic [2:0] addr1,
    output logic [1:0] gnt,
    output logic [1:0] rvalid,
    output logic       rdata0,
    output logic       rdata1,
    input  logic       load_start,
    input  logic       load_bit_valid,
    input  logic       load_bit,
    output logic       load_busy,
    output logic       load_done
);

    localparam logic [7:0] LUT_RESET = 8'hB9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] lut_q;
    logic [2:0] load_idx;
    // Client favoured when both request: 0 -> client 0, 1 -> client 1.
    logic       rr_prio;

    logic [1:0] gnt_p0;
    logic [1:0] rvalid_p1;
    logic       rdata0_p1;
    logic       rdata1_p1;

    // Next-state, grant and load status decode; reset masks every output.
    always_comb begin
        state_next = state;
        gnt_p0     = 2'b00;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                end else begin
                    case (req)
                        2'b01:   gnt_p0 = 2'b01;
                        2'b10:   gnt_p0 = 2'b10;
                        2'b11:   gnt_p0 = rr_prio ? 2'b10 : 2'b01;
                        default: gnt_p0 = 2'b00;
                    endcase
                end
            end
            LOAD: begin
                load_busy = 1'b1;
                if (load_bit_valid && (load_idx == 3'd7)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                load_done  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            state_next = IDLE;
            gnt_p0     = 2'b00;
            load_busy  = 1'b0;
            load_done  = 1'b0;
        end
    end

    assign gnt = gnt_p0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Serial table reload: one entry per qualified LOAD cycle, index cleared outside LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            lut_q    <= LUT_RESET;
            load_idx <= 3'd0;
        end else if (state == LOAD) begin
            if (load_bit_valid) begin
                lut_q[load_idx] <= load_bit;
                load_idx        <= load_idx + 3'd1;
            end
        end else begin
            load_idx <= 3'd0;
        end
    end

    // Round-robin pointer moves only on a granted cycle, away from the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_prio <= 1'b0;
        end else if (gnt_p0[0]) begin
            rr_prio <= 1'b1;
        end else if (gnt_p0[1]) begin
            rr_prio <= 1'b0;
        end
    end

    // ---- stage p0 -> p1: registered lookup, data held when not granted ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_p1 <= 2'b00;
            rdata0_p1 <= 1'b0;
            rdata1_p1 <= 1'b0;
        end else begin
            rvalid_p1 <= gnt_p0;
            if (gnt_p0[0]) begin
                rdata0_p1 <= lut_q[addr0];
            end
            if (gnt_p0[1]) begin
                rdata1_p1 <= lut_q[addr1];
            end
        end
    end

    assign rvalid = rvalid_p1;
    assign rdata0 = rdata0_p1;
    assign rdata1 = rdata1_p1;

endmodule
